sample_demux_four: RTL and testbench
====================================

SAMPLE_DEMUX_FOUR -- requirements
Module: sample_demux_four

Interface
REQ-001 Parameter: DATA_W, default 8, width of one channel sample.
REQ-002 Reset is synchronous and active-high; the block uses one clock. Ports are listed below as name, direction, width, meaning.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream has a sample on in_data.
REQ-006 in_sel  input  2  destination channel 0..3 for the sample.
REQ-007 in_data  input  DATA_W  sample value.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 frame_ack  input  1  consumer has taken the current frame.
REQ-010 out_data  output  4*DATA_W  channel registers, ch0 at bits [DATA_W-1:0], ch3 at the top.
REQ-011 out_fresh  output  4  per-channel written-since-last-frame flags.
REQ-012 frame_valid  output  1  all four channels are fresh and the frame is held.
REQ-013 dup_err  output  1  one-cycle pulse: a channel was rewritten before the frame completed.
REQ-014 frame_cnt  output  8  count of acknowledged frames, wraps 255->0.

Function
REQ-015 A transfer (accept) occurs on a cycle where in_valid=1 and in_ready=1; no other cycle changes channel data.
REQ-016 FSM states: COLLECT and FULL; in_ready=1 in COLLECT and 0 in FULL, decoded from state only (no combinational path from inputs).
REQ-017 On accept, out_data channel in_sel takes in_data and out_fresh[in_sel] sets, both visible the next cycle; other channels are unchanged.
REQ-018 If out_fresh[in_sel] is already 1 when a sample is accepted, the data is overwritten and dup_err pulses high for exactly the next cycle.
REQ-019 In COLLECT, if the accept makes all four out_fresh bits 1 (counting this write), the state moves to FULL on the same edge, so frame_valid=1 and in_ready=0 the next cycle.
REQ-020 frame_valid = (state == FULL).
REQ-021 In FULL, in_valid is ignored; out_data and out_fresh hold.
REQ-022 In FULL with frame_ack=1: the next cycle is COLLECT, out_fresh=0000, frame_cnt increments by 1 modulo 256, and out_data is retained.
REQ-023 frame_ack in COLLECT is ignored: no state change and no count change.
REQ-024 Samples are not required to arrive in channel order; any order that covers all four channels completes a frame.
REQ-025 There is no back-to-back bypass: the earliest accept after frame_ack is the cycle after the FULL->COLLECT transition.

Reset
REQ-026 When rst=1 at a clock edge: state=COLLECT, out_data=0, out_fresh=0000, dup_err=0, frame_cnt=0, so in_ready=1 and frame_valid=0 the next cycle.
REQ-027 rst takes priority over accept and frame_ack on the same edge, including mid-frame and in FULL; any partial frame is discarded.

Verification
REQ-028 Reset, then accept sel 0,1,2,3 with data 0x11,0x22,0x33,0x44 on consecutive cycles -> after the 4th accept: out_data=0x44332211, out_fresh=1111, frame_valid=1, in_ready=0; dup_err is never pulsed.
REQ-029 In FULL, drive in_valid=1 with sel=0 and data 0xFF for 3 cycles, then frame_ack=1 -> out_data is unchanged at 0x44332211; the next cycle shows COLLECT, out_fresh=0000, frame_cnt=1.
REQ-030 Accept sel=2 data 0xAA, then sel=2 data 0xBB -> ch2=0xBB, dup_err=1 for exactly one cycle, out_fresh=0100, frame_valid stays 0.
REQ-031 Accept sel 3,1,0,2 (out of order) -> frame_valid asserts the cycle after the sel-2 accept.
REQ-032 Accept sel 0 and 1, then assert rst with in_valid=1 -> all outputs return to their reset values and the sample in that cycle is not written.
REQ-033 Complete 256 acknowledged frames -> frame_cnt wraps to 0 with no other side effects.

Source files
------------

// File: rtl/sample_demux_four.sv
// sample_demux_four
// Collects one sample per channel (four channels) into a held frame.
// Samples arrive in any channel order; once every channel has been
// written since the last frame, the frame is presented and input is
// stalled until the consumer acknowledges it. Rewriting a channel that
// is already fresh overwrites it and raises a one-cycle duplicate pulse.
module sample_demux_four #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  frame_ack,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_fresh,
  output logic                  frame_valid,
  output logic                  dup_err,
  output logic [7:0]            frame_cnt
);

  // Two-state controller: gathering samples, or holding a complete frame.
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] FULL    = 1'b1;

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [DATA_W-1:0] chan_q [4];
  logic [DATA_W-1:0] chan_d [4];
  logic [3:0]        fresh_q;
  logic [3:0]        fresh_d;
  logic              dupErr_q;
  logic              dupErr_d;
  logic [7:0]        frameCnt_q;
  logic [7:0]        frameCnt_d;

  logic              accept;
  logic              frameDone;
  logic              frameTaken;
  logic [3:0]        selOneHot;
  logic [3:0]        freshMerged;

  // Decode the handshake and work out what the fresh flags would look like
  // with this cycle's write folded in, so frame completion is seen on the
  // same edge as the last sample.
  always_comb begin
    selOneHot   = 4'b0001 << in_sel;
    accept      = in_valid && (state_q == COLLECT);
    freshMerged = fresh_q | (accept ? selOneHot : 4'b0000);
    frameDone   = accept && (&freshMerged);
    frameTaken  = (state_q == FULL) && frame_ack;
  end

  // Next-state logic for the controller, the fresh flags, the duplicate
  // pulse and the frame counter.
  always_comb begin
    state_d    = state_q;
    fresh_d    = fresh_q;
    dupErr_d   = 1'b0;
    frameCnt_d = frameCnt_q;
    case (state_q)
      COLLECT: begin
        fresh_d  = freshMerged;
        dupErr_d = accept && fresh_q[in_sel];
        if (frameDone) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (frameTaken) begin
          state_d    = COLLECT;
          fresh_d    = 4'b0000;
          frameCnt_d = frameCnt_q + 8'd1;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Channel data only moves on an accepted sample; everything else,
  // including frame acknowledge, leaves the last values in place.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      chan_d[c] = chan_q[c];
      if (accept && (in_sel == 2'(c))) begin
        chan_d[c] = in_data;
      end
    end
  end

  // State registers; reset wins over any accept or acknowledge on the same
  // edge and throws away a partially collected frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      fresh_q    <= 4'b0000;
      dupErr_q   <= 1'b0;
      frameCnt_q <= 8'd0;
      for (int c = 0; c < 4; c++) begin
        chan_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fresh_q    <= fresh_d;
      dupErr_q   <= dupErr_d;
      frameCnt_q <= frameCnt_d;
      for (int c = 0; c < 4; c++) begin
        chan_q[c] <= chan_d[c];
      end
    end
  end

  // Pack the channel registers with channel 0 in the lowest slice.
  for (genvar g = 0; g < 4; g++) begin : gPack
    assign out_data[g*DATA_W +: DATA_W] = chan_q[g];
  end

  // Outputs are decoded from registers only, so nothing upstream sees a
  // combinational path back from its own inputs.
  assign in_ready    = (state_q == COLLECT);
  assign frame_valid = (state_q == FULL);
  assign out_fresh   = fresh_q;
  assign dup_err     = dupErr_q;
  assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_sample_demux_four.sv
// tb_sample_demux_four
// Directed vectors for sample_demux_four. The driver pushes the expected
// post-edge outputs into a scoreboard queue; an independent monitor pops
// and compares them on the falling edge after the edge they belong to.
module tb_sample_demux_four;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic [1:0]          in_sel = 2'd0;
  logic [DATA_W-1:0]   in_data = '0;
  logic                in_ready;
  logic                frame_ack = 1'b0;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]          out_fresh;
  logic                frame_valid;
  logic                dup_err;
  logic [7:0]          frame_cnt;

  typedef struct {
    string       name;
    int          due;
    logic [31:0] data;
    logic [3:0]  fresh;
    logic        fv;
    logic        ready;
    logic        dup;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sbQ[$];
  int          cycleCnt = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic [7:0]  prevCh [4];

  sample_demux_four #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sel      (in_sel),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .frame_ack   (frame_ack),
    .out_data    (out_data),
    .out_fresh   (out_fresh),
    .frame_valid (frame_valid),
    .dup_err     (dup_err),
    .frame_cnt   (frame_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Count rising edges so each expectation knows which edge it belongs to.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s %s actual=0x%0h required=0x%0h", name, field, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input string name, input bit rstV, input bit validV,
                               input logic [1:0] selV, input logic [7:0] dataV,
                               input bit ackV, input logic [31:0] eData,
                               input logic [3:0] eFresh, input bit eFv,
                               input bit eDup, input logic [7:0] eCnt);
    exp_t e;
    rst       = rstV;
    in_valid  = validV;
    in_sel    = selV;
    in_data   = dataV;
    frame_ack = ackV;
    e.name  = name;
    e.due   = cycleCnt + 1;
    e.data  = eData;
    e.fresh = eFresh;
    e.fv    = eFv;
    e.ready = !eFv;
    e.dup   = eDup;
    e.cnt   = eCnt;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each falling edge, check every expectation that has come due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbQ.size() > 0 && sbQ[0].due <= cycleCnt) begin
        e = sbQ.pop_front();
        checkOutput(e.name, "out_data",    out_data,           e.data);
        checkOutput(e.name, "out_fresh",   {28'd0, out_fresh}, {28'd0, e.fresh});
        checkOutput(e.name, "frame_valid", {31'd0, frame_valid}, {31'd0, e.fv});
        checkOutput(e.name, "in_ready",    {31'd0, in_ready},  {31'd0, e.ready});
        checkOutput(e.name, "dup_err",     {31'd0, dup_err},   {31'd0, e.dup});
        checkOutput(e.name, "frame_cnt",   {24'd0, frame_cnt}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    applyStimulus("reset0", 1, 0, 0, 8'h00, 0, 32'h0, 4'b0000, 0, 0, 8'd0);
    applyStimulus("reset1", 1, 1, 2, 8'hEE, 1, 32'h0, 4'b0000, 0, 0, 8'd0);

    // In-order fill
    applyStimulus("fill0", 0, 1, 0, 8'h11, 0, 32'h00000011, 4'b0001, 0, 0, 8'd0);
    applyStimulus("fill1", 0, 1, 1, 8'h22, 0, 32'h00002211, 4'b0011, 0, 0, 8'd0);
    applyStimulus("fill2", 0, 1, 2, 8'h33, 0, 32'h00332211, 4'b0111, 0, 0, 8'd0);
    applyStimulus("fill3", 0, 1, 3, 8'h44, 0, 32'h44332211, 4'b1111, 1, 0, 8'd0);

    // Input ignored while FULL, then acknowledge
    for (int k = 0; k < 3; k++)
      applyStimulus($sformatf("fullhold%0d", k), 0, 1, 0, 8'hFF, 0,
                    32'h44332211, 4'b1111, 1, 0, 8'd0);
    applyStimulus("ack1", 0, 1, 0, 8'hFF, 1, 32'h44332211, 4'b0000, 0, 0, 8'd1);

    // Acknowledge while collecting is ignored
    applyStimulus("ackIdle", 0, 0, 0, 8'h00, 1, 32'h44332211, 4'b0000, 0, 0, 8'd1);

    // Out-of-order fill completes on the sel-2 accept
    applyStimulus("ooo3", 0, 1, 3, 8'h55, 0, 32'h55332211, 4'b1000, 0, 0, 8'd1);
    applyStimulus("ooo1", 0, 1, 1, 8'h66, 0, 32'h55336611, 4'b1010, 0, 0, 8'd1);
    applyStimulus("ooo0", 0, 1, 0, 8'h77, 0, 32'h55336677, 4'b1011, 0, 0, 8'd1);
    applyStimulus("oooGap", 0, 0, 2, 8'h99, 0, 32'h55336677, 4'b1011, 0, 0, 8'd1);
    applyStimulus("ooo2", 0, 1, 2, 8'h88, 0, 32'h55886677, 4'b1111, 1, 0, 8'd1);
    applyStimulus("ack2", 0, 0, 0, 8'h00, 1, 32'h55886677, 4'b0000, 0, 0, 8'd2);

    // Duplicate write to channel 2
    applyStimulus("dupA", 0, 1, 2, 8'hAA, 0, 32'h55AA6677, 4'b0100, 0, 0, 8'd2);
    applyStimulus("dupB", 0, 1, 2, 8'hBB, 0, 32'h55BB6677, 4'b0100, 0, 1, 8'd2);
    applyStimulus("dupEnd", 0, 0, 0, 8'h00, 0, 32'h55BB6677, 4'b0100, 0, 0, 8'd2);

    // Reset mid-frame with a sample offered on the same edge
    applyStimulus("mid0", 0, 1, 0, 8'h01, 0, 32'h55BB6601, 4'b0101, 0, 0, 8'd2);
    applyStimulus("mid1", 0, 1, 1, 8'h02, 0, 32'h55BB0201, 4'b0111, 0, 0, 8'd2);
    applyStimulus("midRst", 1, 1, 3, 8'h99, 0, 32'h0, 4'b0000, 0, 0, 8'd0);

    // Reset while FULL with an acknowledge on the same edge
    applyStimulus("rf0", 0, 1, 0, 8'hA0, 0, 32'h000000A0, 4'b0001, 0, 0, 8'd0);
    applyStimulus("rf1", 0, 1, 1, 8'hA1, 0, 32'h0000A1A0, 4'b0011, 0, 0, 8'd0);
    applyStimulus("rf2", 0, 1, 2, 8'hA2, 0, 32'h00A2A1A0, 4'b0111, 0, 0, 8'd0);
    applyStimulus("rf3", 0, 1, 3, 8'hA3, 0, 32'hA3A2A1A0, 4'b1111, 1, 0, 8'd0);
    applyStimulus("fullRst", 1, 1, 0, 8'h12, 1, 32'h0, 4'b0000, 0, 0, 8'd0);

    // 256 acknowledged frames: the counter wraps back to zero
    for (int c = 0; c < 4; c++) prevCh[c] = 8'h00;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 4; i++) begin
        prevCh[i] = 8'(f * 4 + i);
        applyStimulus($sformatf("wrap%0d_%0d", f, i), 0, 1, 2'(i), prevCh[i], 0,
                      {prevCh[3], prevCh[2], prevCh[1], prevCh[0]},
                      4'((1 << (i + 1)) - 1), (i == 3), 0, 8'(f));
      end
      applyStimulus($sformatf("wrapAck%0d", f), 0, 0, 0, 8'h00, 1,
                    {prevCh[3], prevCh[2], prevCh[1], prevCh[0]},
                    4'b0000, 0, 0, 8'(f + 1));
    end
    applyStimulus("postWrap", 0, 1, 0, 8'h5A, 0,
                  {prevCh[3], prevCh[2], prevCh[1], 8'h5A}, 4'b0001, 0, 0, 8'd0);
    applyStimulus("idleEnd", 0, 0, 0, 8'h00, 0,
                  {prevCh[3], prevCh[2], prevCh[1], 8'h5A}, 4'b0001, 0, 0, 8'd0);

    // Let the monitor drain, bounded
    for (int w = 0; w < 10 && sbQ.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
